// File: rtl/project_types_pkg.sv
// Shared pipeline types and constants for the MIPS core.
// Provides instruction/address types, fetch FSM states and ROM enable levels.
package project_types;

  localparam int PKG_ADDR_W = 32;
  localparam int PC_STEP    = 4;

  typedef logic [31:0]           inst_data_t;
  typedef logic [PKG_ADDR_W-1:0] addr_t;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: flush squashes, stall holds, boot inserts a bubble.
module if_id_reg
  import project_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_boot,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic [ADDR_W-1:0] i_pc,
  input  inst_data_t        i_inst,
  output logic [ADDR_W-1:0] o_id_pc,
  output inst_data_t        o_id_inst,
  output logic              o_id_valid
);

  logic [ADDR_W-1:0] r_id_pc;
  inst_data_t        r_id_inst;
  logic              r_id_valid;

  // Boot is checked first so flush/stall cannot act before the first fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (i_boot) begin
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (i_flush) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (!i_stall) begin
      r_id_pc    <= i_pc;
      r_id_inst  <= i_inst;
      r_id_valid <= 1'b1;
    end
  end

  assign o_id_pc    = r_id_pc;
  assign o_id_inst  = r_id_inst;
  assign o_id_valid = r_id_valid;

endmodule

// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: PC/next-PC logic, ROM drive, IF/ID capture.
// Optional macro INST_FETCH_PERF_EN adds saturating fetch/stall counters.
module inst_fetch
  import project_types::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              inst_en,
  output logic [ADDR_W-1:0] inst_addr,
  input  inst_data_t        inst_data,
  output logic [ADDR_W-1:0] id_pc,
  output inst_data_t        id_inst,
  output logic              id_valid
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_target;
  logic              r_pend_valid;
  logic              w_run;
  logic [ADDR_W-1:0] w_branch_aligned;
  logic [ADDR_W-1:0] w_flush_aligned;

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    inst_en      = CHIP_DISABLE;
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        w_state_next = RUN;
        inst_en      = CHIP_ENABLE;
      end
      default: w_state_next = BOOT;
    endcase
  end

  assign w_run            = (r_state == RUN);
  assign w_branch_aligned = {branch_target[ADDR_W-1:2], 2'b00};
  assign w_flush_aligned  = {flush_pc[ADDR_W-1:2], 2'b00};

  // A fresh branch outranks a pending one; either way the pending slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_pend_target <= '0;
      r_pend_valid  <= 1'b0;
    end else if (w_run) begin
      if (flush) begin
        r_pc         <= w_flush_aligned;
        r_pend_valid <= 1'b0;
      end else if (stall) begin
        if (branch_taken) begin
          r_pend_target <= w_branch_aligned;
          r_pend_valid  <= 1'b1;
        end
      end else if (branch_taken) begin
        r_pc         <= w_branch_aligned;
        r_pend_valid <= 1'b0;
      end else if (r_pend_valid) begin
        r_pc         <= r_pend_target;
        r_pend_valid <= 1'b0;
      end else begin
        r_pc <= r_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  assign inst_addr = r_pc;

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_boot    (!w_run),
    .i_flush   (flush),
    .i_stall   (stall),
    .i_pc      (r_pc),
    .i_inst    (inst_data),
    .o_id_pc   (id_pc),
    .o_id_inst (id_inst),
    .o_id_valid(id_valid)
  );

`ifdef INST_FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (w_run) begin
      if (!flush && !stall && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (!flush && stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the instruction ROM and drives its enable and address.
- Holds the PC and computes the next PC: sequential, branch redirect, or exception flush.
- Captures the ROM's combinational read data into the IF/ID pipeline register for the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- ADDR_W, 32, width of PC and all address ports.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  exception/eret: redirect to flush_pc and squash IF/ID.
- flush_pc  input  ADDR_W  redirect target for flush.
- branch_taken  input  1  decode stage resolved a taken branch/jump.
- branch_target  input  ADDR_W  branch/jump destination.
- inst_en  output  1  ROM chip enable; 1 = enabled.
- inst_addr  output  ADDR_W  ROM byte address (equals pc).
- inst_data  input  32  ROM read data, combinational from inst_addr.
- id_pc  output  ADDR_W  PC of instruction in IF/ID.
- id_inst  output  32  instruction in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- FSM states are BOOT and RUN. On rst: state=BOOT, pc=RESET_PC, pend_valid=0, id_pc=0, id_inst=0, id_valid=0.
- In BOOT, inst_en=0. The next cycle moves to RUN unconditionally; stall/flush/branch are ignored in BOOT.
- In RUN, inst_en=1.
- inst_addr=pc, always combinational.
- Next PC is evaluated in RUN only. Priority: rst > flush > stall > pending/branch > sequential.
  - flush: pc<=flush_pc; pend_valid<=0.
  - stall: pc holds. If branch_taken=1 also, latch pend_target<=branch_target and pend_valid<=1. A newer branch_taken during stall overwrites pend_target.
  - not stalled, pend_valid=1: pc<=pend_target; pend_valid<=0. A same-cycle branch_taken takes precedence over the pending target.
  - not stalled, branch_taken=1: pc<=branch_target.
  - otherwise: pc<=pc+4, wrapping modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- Branch targets and flush_pc have bits [1:0] forced to 00 when loaded; pc is always word-aligned.
- Delay slot: the instruction fetched in the cycle branch_taken is asserted is the delay slot. It is captured normally and not squashed; the redirect takes effect on the following fetch.
- IF/ID register, one-cycle latency:
  - flush=1: id_inst<=0, id_pc<=0, id_valid<=0.
  - stall=1: all hold.
  - BOOT: id_valid<=0, id_inst<=0.
  - else: id_inst<=inst_data, id_pc<=pc, id_valid<=1.
- Simultaneous flush and stall: flush wins for both PC and IF/ID.
- rst asserted mid-operation returns to BOOT next edge, discarding any pending redirect.

Optional Feature:
- Macro: INST_FETCH_PERF_EN.
- Enabled: extra outputs perf_fetch_cnt and perf_stall_cnt (32 bits each, reset 0).
  - perf_fetch_cnt increments each RUN cycle that writes IF/ID with id_valid<=1.
  - perf_stall_cnt increments each RUN cycle with stall=1 and flush=0.
  - Both saturate at 32'hFFFF_FFFF.
- Disabled: ports and counters absent; no other behavioural change.

Decomposition:
- project_types package gains:
  - addr_t (ADDR_W-bit PC type)
  - fetch_state_e enum {BOOT, RUN}
  - PC_STEP=4
- The package's existing inst_data_t and chip-enable constants are used for inst_data and inst_en.
- Natural sub-module: if_id_reg, holding the IF/ID register with stall/flush semantics. PC and FSM logic stay in inst_fetch.

Test Plan:
- Reset then run 4 cycles, no stall: inst_en 0 in cycle 1, then inst_addr 0x0, 0x4, 0x8. IF/ID shows id_pc 0x0, 0x4 with id_valid=1 one cycle after each fetch.
- stall=1 for 2 cycles at pc=0x10: inst_addr stays 0x10, id_pc/id_inst unchanged. After release, the next fetch is 0x14.
- branch_taken=1, target 0x200, while pc=0x24 (delay slot): 0x24 is captured into IF/ID, next inst_addr=0x200.
- stall=1 and branch_taken=1 (target 0x300) in the same cycle, then stall=0 with branch_taken=0: inst_addr=0x300 after release.
- flush=1, flush_pc=0x180, with stall=1 and pend_valid set: inst_addr=0x180 next, id_valid=0, pending redirect discarded.
- pc=32'hFFFF_FFFC, no events: next inst_addr=0x0. Misaligned branch_target 0x203 loads pc=0x200.
